// File: rtl/conv_stream_array.sv
// Streaming K x K 2-D convolution engine.
// Weights are loaded once in raster order and kept until the next load.
// Pixels stream in raster order through K-1 line buffers and a K x K
// window; every window lying fully inside the image yields one result in
// a single-entry output register one cycle after the completing pixel.
module conv_stream_array #(
    parameter int DATA_W = 16,
    parameter int K      = 3,
    parameter int IMG_W  = 5,
    parameter int IMG_H  = 5,
    parameter int ACC_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     filt_valid,
    input  logic signed [DATA_W-1:0] filt_data,
    output logic                     filt_ready,
    input  logic                     pix_valid,
    input  logic signed [DATA_W-1:0] pix_data,
    output logic                     pix_ready,
    output logic                     out_valid,
    output logic signed [ACC_W-1:0]  out_data,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     done
);

    localparam int KK  = K * K;
    localparam int WCW = $clog2(KK);
    localparam int CW  = $clog2(IMG_W);
    localparam int RW  = $clog2(IMG_H);

    localparam logic [WCW-1:0] W_LAST    = WCW'(KK - 1);
    localparam logic [CW-1:0]  COL_LAST  = CW'(IMG_W - 1);
    localparam logic [CW-1:0]  COL_FIRST = CW'(K - 1);
    localparam logic [RW-1:0]  ROW_LAST  = RW'(IMG_H - 1);
    localparam logic [RW-1:0]  ROW_FIRST = RW'(K - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_STREAM
    } state_t;

    // Full-precision product, sign-extended and added with wrap-around.
    function automatic logic signed [ACC_W-1:0] f_mac(
        input logic signed [ACC_W-1:0]  acc,
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        logic signed [2*DATA_W-1:0] prod;
        prod = (2*DATA_W)'(a) * (2*DATA_W)'(b);
        return acc + ACC_W'(prod);
    endfunction

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic                      r_wloaded;
    logic [WCW-1:0]            r_wcnt;
    logic [CW-1:0]             r_col;
    logic [RW-1:0]             r_row;
    logic                      r_frame_end;

    logic signed [DATA_W-1:0]  r_wgt [0:KK-1];
    logic signed [DATA_W-1:0]  r_lb  [0:K-2][0:IMG_W-1];
    logic signed [DATA_W-1:0]  r_win [0:K-1][0:K-1];

    logic signed [DATA_W-1:0]  w_col     [0:K-1];
    logic signed [DATA_W-1:0]  w_win_nxt [0:K-1][0:K-1];
    logic signed [ACC_W-1:0]   w_sum;

    logic                      r_vld_p1;
    logic signed [ACC_W-1:0]   r_sum_p1;

    logic                      w_filt_acc;
    logic                      w_pix_acc;
    logic                      w_win_ok;
    logic                      w_last_pix;
    logic                      w_done;

    // Pixels stop after the last one of the frame until the final result drains.
    assign filt_ready = (r_state == S_LOAD) & en;
    assign pix_ready  = (r_state == S_STREAM) & en & ~r_frame_end & (~r_vld_p1 | out_ready);
    assign w_filt_acc = filt_valid & filt_ready;
    assign w_pix_acc  = pix_valid & pix_ready;
    assign w_win_ok   = (r_row >= ROW_FIRST) & (r_col >= COL_FIRST);
    assign w_last_pix = (r_row == ROW_LAST) & (r_col == COL_LAST);
    assign w_done     = (r_state == S_STREAM) & en & r_frame_end & r_vld_p1 & out_ready;

    assign busy      = (r_state != S_IDLE);
    assign done      = w_done;
    assign out_valid = r_vld_p1;
    assign out_data  = r_sum_p1;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic; nothing moves while en is low.
    always_comb begin
        w_state_nxt = r_state;
        if (en) begin
            case (r_state)
                S_IDLE: begin
                    if (filt_valid) begin
                        w_state_nxt = S_LOAD;
                    end else if (pix_valid && r_wloaded) begin
                        w_state_nxt = S_STREAM;
                    end
                end
                S_LOAD: begin
                    if (w_filt_acc && (r_wcnt == W_LAST)) begin
                        w_state_nxt = S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (w_done) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Weight counter, pixel position counters and frame bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wloaded   <= 1'b0;
            r_wcnt      <= '0;
            r_col       <= '0;
            r_row       <= '0;
            r_frame_end <= 1'b0;
        end else if (en) begin
            if (r_state == S_IDLE) begin
                r_wcnt      <= '0;
                r_col       <= '0;
                r_row       <= '0;
                r_frame_end <= 1'b0;
            end
            if (w_filt_acc) begin
                if (r_wcnt == W_LAST) begin
                    r_wcnt    <= '0;
                    r_wloaded <= 1'b1;
                end else begin
                    r_wcnt <= r_wcnt + 1'b1;
                end
            end
            if (w_pix_acc) begin
                if (r_col == COL_LAST) begin
                    r_col <= '0;
                    r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
                if (w_last_pix) begin
                    r_frame_end <= 1'b1;
                end
            end
        end
    end

    // Incoming column (oldest row on top) and the window after this pixel shifts in.
    always_comb begin
        w_sum = '0;
        for (int r = 0; r < K - 1; r++) begin
            w_col[r] = r_lb[K-2-r][r_col];
        end
        w_col[K-1] = pix_data;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) begin
                w_win_nxt[r][c] = r_win[r][c+1];
            end
            w_win_nxt[r][K-1] = w_col[r];
        end
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                w_sum = f_mac(w_sum, r_wgt[r*K+c], w_win_nxt[r][c]);
            end
        end
    end

    // Weight store, line buffers and window shift register (data only, never cleared).
    always_ff @(posedge clk) begin
        if (en) begin
            if (w_filt_acc) begin
                r_wgt[r_wcnt] <= filt_data;
            end
            if (w_pix_acc) begin
                for (int j = K - 2; j >= 1; j--) begin
                    r_lb[j][r_col] <= r_lb[j-1][r_col];
                end
                r_lb[0][r_col] <= pix_data;
                for (int r = 0; r < K; r++) begin
                    for (int c = 0; c < K; c++) begin
                        r_win[r][c] <= w_win_nxt[r][c];
                    end
                end
            end
        end
    end

    // ---- stage p1: single-entry output register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1 <= 1'b0;
            r_sum_p1 <= '0;
        end else if (en) begin
            if (w_pix_acc && w_win_ok) begin
                r_vld_p1 <= 1'b1;
                r_sum_p1 <= w_sum;
            end else if (r_vld_p1 && out_ready) begin
                r_vld_p1 <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv_stream_array.sv
// Directed bench for conv_stream_array with K=3 on a 5x5 image.
module tb_conv_stream_array;

    localparam int DATA_W = 16;
    localparam int K      = 3;
    localparam int IMG_W  = 5;
    localparam int IMG_H  = 5;
    localparam int ACC_W  = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              filt_valid;
    logic [DATA_W-1:0] filt_data;
    logic              filt_ready;
    logic              pix_valid;
    logic [DATA_W-1:0] pix_data;
    logic              pix_ready;
    logic              out_valid;
    logic [ACC_W-1:0]  out_data;
    logic              out_ready;
    logic              busy;
    logic              done;

    int total = 0;
    int bad   = 0;
    int npx;

    logic [DATA_W-1:0] wv   [0:8];
    logic [DATA_W-1:0] pix  [0:24];
    logic [ACC_W-1:0]  expv [0:8];

    always #5 clk = ~clk;

    conv_stream_array #(
        .DATA_W(DATA_W),
        .K(K),
        .IMG_W(IMG_W),
        .IMG_H(IMG_H),
        .ACC_W(ACC_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .filt_valid(filt_valid),
        .filt_data(filt_data),
        .filt_ready(filt_ready),
        .pix_valid(pix_valid),
        .pix_data(pix_data),
        .pix_ready(pix_ready),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_ready(out_ready),
        .busy(busy),
        .done(done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic load_w();
        int i = 0;
        for (int c = 0; c < 60 && i < 9; c++) begin
            @(negedge clk);
            en = 1'b1;
            filt_valid = 1'b1;
            filt_data = wv[i];
            #1;
            if (filt_ready) i++;
        end
        chk("load_count", i, 9);
        @(negedge clk);
        filt_valid = 1'b0;
        #1;
        chk("load_busy", 32'(busy), 1);
        chk("load_filt_ready_off", 32'(filt_ready), 0);
    endtask

    task automatic run_frame(input int tgl, input int gap);
        int pi = 0;
        int ri = 0;
        int nd = 0;
        int gc = 0;
        int post = -1;
        logic hv = 1'b0;
        logic [ACC_W-1:0] hd = '0;
        for (int cyc = 0; cyc < 400 && post != 0; cyc++) begin
            @(negedge clk);
            en = !(gap >= 0 && pi == gap && gc < 5);
            if (!en) gc++;
            if (pi < 25) begin
                pix_valid = 1'b1;
                pix_data = pix[pi];
            end else begin
                pix_valid = 1'b0;
                pix_data = '0;
            end
            out_ready = (tgl != 0) ? (cyc % 2 == 0) : 1'b1;
            #1;
            if (!en) chk("en0_no_handshake", 32'({pix_ready, filt_ready, done}), 0);
            if (hv) begin
                chk("stall_valid", 32'(out_valid), 1);
                chk("stall_data", out_data, hd);
            end
            if (post > 0) chk("post_idle", 32'({busy, out_valid}), 0);
            if (out_valid && out_ready && en) begin
                if (ri < 9) chk($sformatf("result%0d", ri), out_data, expv[ri]);
                else chk("result_overrun", ri, 8);
                ri++;
            end
            if (done) begin
                nd++;
                post = 3;
            end else if (post > 0) begin
                post--;
            end
            hv = out_valid && !(out_ready && en);
            hd = out_data;
            if (pix_valid && pix_ready) pi++;
        end
        pix_valid = 1'b0;
        en = 1'b1;
        chk("pix_count", pi, 25);
        chk("result_count", ri, 9);
        chk("done_count", nd, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        en = 1'b0;
        filt_valid = 1'b0;
        filt_data = '0;
        pix_valid = 1'b0;
        pix_data = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        en = 1'b1;
        pix_valid = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_filt_ready", 32'(filt_ready), 0);
        chk("rst_pix_ready_noload", 32'(pix_ready), 0);
        @(negedge clk);
        #1;
        chk("idle_noload_busy", 32'(busy), 0);
        pix_valid = 1'b0;

        // all ones -> nine results of 9
        for (int i = 0; i < 9; i++) begin wv[i] = 16'd1; expv[i] = 32'd9; end
        for (int i = 0; i < 25; i++) pix[i] = 16'd1;
        load_w();
        run_frame(0, -1);

        // centre tap only over a ramp image
        for (int i = 0; i < 9; i++) wv[i] = (i == 4) ? 16'd1 : 16'd0;
        for (int i = 0; i < 25; i++) pix[i] = 16'(i);
        expv[0] = 32'd6;  expv[1] = 32'd7;  expv[2] = 32'd8;
        expv[3] = 32'd11; expv[4] = 32'd12; expv[5] = 32'd13;
        expv[6] = 32'd16; expv[7] = 32'd17; expv[8] = 32'd18;
        load_w();
        run_frame(0, -1);

        // same frame with retained weights, consumer stalling every other cycle
        run_frame(1, -1);

        // same frame with a five-cycle enable gap at pixel 12
        run_frame(0, 12);

        // negative weights against full-scale pixels
        for (int i = 0; i < 9; i++) begin wv[i] = 16'hFFFF; expv[i] = 32'hFFFB8009; end
        for (int i = 0; i < 25; i++) pix[i] = 16'h7FFF;
        load_w();
        run_frame(0, -1);

        // reset mid-frame, then pixels without a reload are refused
        for (int i = 0; i < 9; i++) begin wv[i] = 16'd1; expv[i] = 32'd9; end
        for (int i = 0; i < 25; i++) pix[i] = 16'd1;
        load_w();
        npx = 0;
        for (int c = 0; c < 100 && npx < 12; c++) begin
            @(negedge clk);
            en = 1'b1;
            pix_valid = 1'b1;
            pix_data = 16'd1;
            out_ready = 1'b1;
            #1;
            if (pix_ready) npx++;
        end
        chk("partial_count", npx, 12);
        @(negedge clk);
        pix_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        pix_valid = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_busy", 32'(busy), 0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            chk("noload_pix_ready", 32'({pix_ready, busy}), 0);
        end
        pix_valid = 1'b0;
        load_w();
        run_frame(0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv_stream_array.md
CONV_STREAM_ARRAY -- requirements
Module: conv_stream_array

Interface
REQ-001 Parameter DATA_W, default 16: pixel and weight width, signed two's complement.
REQ-002 Parameter K, default 3: filter side; the filter is K x K; legal range 2..7.
REQ-003 Parameter IMG_W, default 5: ifmap width in pixels; must be >= K.
REQ-004 Parameter IMG_H, default 5: ifmap height in pixels; must be >= K.
REQ-005 Parameter ACC_W, default 32: result width; must be >= 2*DATA_W.
REQ-006 clk  in  1  sole clock; all state updates on its rising edge.
REQ-007 rst  in  1  reset; synchronous and active-high.
REQ-008 en  in  1  global enable; 0 freezes all state.
REQ-009 filt_valid  in  1  weight word offered.
REQ-010 filt_data  in  DATA_W  weight word, raster order: row 0 col 0 first.
REQ-011 filt_ready  out  1  weight accepted when filt_valid & filt_ready.
REQ-012 pix_valid  in  1  pixel offered.
REQ-013 pix_data  in  DATA_W  ifmap pixel, raster order.
REQ-014 pix_ready  out  1  pixel accepted when pix_valid & pix_ready.
REQ-015 out_valid  out  1  result available.
REQ-016 out_data  out  ACC_W  convolution result.
REQ-017 out_ready  in  1  result consumed when out_valid & out_ready.
REQ-018 busy  out  1  high in LOAD and STREAM.
REQ-019 done  out  1  one-cycle pulse at frame completion.

Function
REQ-020 The FSM SHALL have states IDLE, LOAD, STREAM; all transitions qualify on en=1.
REQ-021 IDLE: filt_valid=1 -> LOAD. Else pix_valid=1 and weights_loaded=1 -> STREAM. filt_valid has priority.
REQ-022 filt_ready SHALL be 1 only in LOAD; pix_ready SHALL be 0 in IDLE and LOAD.
REQ-023 LOAD: accept K*K weights; on the K*K-th accept, set weights_loaded and go to STREAM.
REQ-024 STREAM: pixels enter K-1 line buffers of IMG_W entries plus a K x K window register; column and row counters wrap at IMG_W and IMG_H.
REQ-025 A result SHALL be produced only for windows fully inside the image (row >= K-1, col >= K-1); no padding.
REQ-026 Each frame therefore produces (IMG_H-K+1)*(IMG_W-K+1) results in raster order.
REQ-027 Each result is sum over (r,c) of w[r][c]*p[row-K+1+r][col-K+1+c].
REQ-028 Each product is a full 2*DATA_W signed value, sign-extended to ACC_W; the sum wraps modulo 2^ACC_W (no saturation).
REQ-029 out_valid SHALL rise the cycle after acceptance of the pixel that completes a valid window; latency is 1 cycle.
REQ-030 The output register holds one entry; pix_ready = (state==STREAM) & en & (~out_valid | out_ready).
REQ-031 A simultaneous output consume and new result in the same cycle SHALL keep out_valid=1 with the new data.
REQ-032 out_data and out_valid SHALL stay stable while out_valid=1 and out_ready=0.
REQ-033 After the last pixel of the frame is accepted, stop accepting pixels; on the handshake of the last result, pulse done and go to IDLE.
REQ-034 Weights SHALL be retained across frames until a new LOAD; a new LOAD overwrites all K*K weights.
REQ-035 en=0: counters, FSM, buffers and output are frozen; filt_ready=0, pix_ready=0, done=0; out_valid and out_data hold.

Reset
REQ-036 rst=1 at a clock edge (priority over en) SHALL set:
- state=IDLE, weights_loaded=0, counters=0, out_valid=0, out_data=0, done=0, busy=0, filt_ready=0, pix_ready=0.
REQ-037 Reset mid-frame SHALL discard the partial frame; a fresh LOAD is required before the next STREAM.
REQ-038 Line-buffer and weight contents need not be cleared.

Verification (K=3, IMG_W=IMG_H=5, DATA_W=16, ACC_W=32)
REQ-039 Stimulus: all weights 1, 25 pixels of 1, out_ready=1 -> exactly 9 results of 9, then a single done pulse.
REQ-040 Stimulus: centre weight 1, others 0; pixels 0..24 -> results 6,7,8,11,12,13,16,17,18.
REQ-041 Stimulus: repeat REQ-040 with out_ready toggling 1/0 every cycle -> identical sequence, no loss or duplication, out_data stable while stalled.
REQ-042 Stimulus: all weights -1, all pixels 32767 -> every result is -294903 (0xFFFB8009).
REQ-043 Stimulus: rst after 12 pixels, then pixel offers without LOAD -> pix_ready stays 0; after reload, REQ-039 passes.
REQ-044 Stimulus: en=0 for 5 cycles mid-frame with valids high -> no handshakes, no state change; the result sequence is unchanged after resume.
